apb_rr_master: RTL

- APB master controller sharing one APB bus between NREQ local requesters through a round-robin arbiter.
- Accepts simple valid/ready transfer requests and sequences the APB SETUP and ENABLE phases.
- Decodes Paddr into one-hot Pselx and returns read data or a decode error to the granted requester.
- Sits on the APB side of the bridge; drives the same Penable/Pwrite/Pwdata/Paddr/Pselx/Prdata bus the APB slaves and monitor use. No Pready: every transfer is exactly SETUP + ENABLE.

---
 rtl/apb_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/apb_rr_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types, slave map and address decode
// for the round-robin APB master.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ENABLE
  } apb_state_e;

  localparam int NSLV_MAP = 4;

  localparam logic [7:0] SLV_BASE [0:NSLV_MAP-1] =
    '{8'h80, 8'h81, 8'h82, 8'h83};

  function automatic logic [NSLV_MAP-1:0] apb_decode(
    input logic [31:0] addr
  );
    logic [NSLV_MAP-1:0] sel;
    sel = '0;
    for (int i = 0; i < NSLV_MAP; i++) begin
      if (addr[31:24] == SLV_BASE[i]) sel[i] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant the first request at or
// after the pointer; the pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt_o = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters: arbitrate,
// run SETUP/ENABLE, return read data or decode error.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
) (
  input  logic                   clock,
  input  logic                   Hresetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      Paddr,
  output logic                   Pwrite,
  output logic [DATA_W-1:0]      Pwdata,
  output logic [NSLV-1:0]        Pselx,
  output logic                   Penable,
  input  logic [DATA_W-1:0]      Prdata
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NREQ-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic [NREQ-1:0]   gnt;
  logic              can_acc;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  assign can_acc   = (state_q == IDLE) || (state_q == ENABLE);
  assign req_ready = gnt & {NREQ{can_acc & Hresetn}};
  assign accept    = |req_ready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk_i  (clock),
    .rst_ni (Hresetn),
    .req_i  (req_valid),
    .adv_i  (accept),
    .gnt_o  (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    owner_d   = owner_q;
    rvalid_d  = '0;
    rdata_d   = '0;
    rerr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
      SETUP: begin
        state_d   = ENABLE;
        penable_d = 1'b1;
      end
      ENABLE: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
        rvalid_d  = owner_q;
        rerr_d    = ~|psel_q;
        if (!pwrite_q && |psel_q) rdata_d = Prdata;
      end
      default: state_d = IDLE;
    endcase
    // A grant in ENABLE chains straight into the next SETUP
    if (accept) begin
      state_d   = SETUP;
      owner_d   = req_ready;
      paddr_d   = sel_addr;
      pwrite_d  = sel_write;
      psel_d    = NSLV'(apb_decode(32'(sel_addr)));
      penable_d = 1'b0;
      if (sel_write) pwdata_d = sel_wdata;
    end
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      owner_q   <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      owner_q   <= owner_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
    end
  end

  assign Paddr     = paddr_q;
  assign Pwrite    = pwrite_q;
  assign Pwdata    = pwdata_q;
  assign Pselx     = psel_q;
  assign Penable   = penable_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule
